// File: rtl/seg_display_arb_pkg.sv
// rtl/seg_display_arb_pkg.sv - shared types, limits and helpers for the display arbiter
package seg_display_arb_pkg;

    typedef enum logic {
        IDLE,
        HOLD
    } arb_state_t;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_display_arb_if.sv
// rtl/seg_display_arb_if.sv - requester-side and display-side signals of the arbiter
interface seg_display_arb_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_in;
    logic [32*N_REQ-1:0] val_in;
    logic [N_REQ-1:0]    grant_out;
    logic [2:0]          owner_out;
    logic [31:0]         val_out;
    logic                blank_out;
    logic                switch_out;

    modport master (
        output req_in, val_in,
        input  grant_out, owner_out, val_out, blank_out, switch_out
    );

    modport slave (
        input  req_in, val_in,
        output grant_out, owner_out, val_out, blank_out, switch_out
    );
endinterface

// File: rtl/disp_rr_pick.sv
// rtl/disp_rr_pick.sv - combinational round-robin picker: first candidate at or after start
module disp_rr_pick
    import seg_display_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    input  logic [N_REQ-1:0] excl,
    output logic             found,
    output logic [IDX_W-1:0] win
);

    logic [N_REQ-1:0]   cand;
    logic [MAX_REQ-1:0] win_oh;
    int                 best_d;
    int                 d;

    assign cand = req & ~excl;

    // Winner is the candidate with the smallest rotational distance from start.
    always_comb begin
        found  = 1'b0;
        win_oh = '0;
        best_d = N_REQ;
        d      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            d = (i + N_REQ - int'(start)) % N_REQ;
            if (cand[i] && d < best_d) begin
                best_d    = d;
                win_oh    = '0;
                win_oh[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign win = onehot_to_idx(win_oh);

endmodule

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin owner of the 8-digit display with minimum dwell
// Optional: SEG_DISPLAY_ARB_PREEMPT_EN makes requester 0 an urgent, preempting source.
module seg_display_arbiter
    import seg_display_arb_pkg::*;
#(
    parameter int          N_REQ        = 4,
    parameter int          DWELL_CYCLES = 100_000_000,
    parameter logic [31:0] IDLE_VAL     = 32'h0000_0000
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    seg_display_arb_if.slave bus
);

    localparam int               CNT_W    = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] win_idx;
    logic [N_REQ-1:0] excl;
    logic             found;
    logic             owner_req;
    logic             at_max;
    logic             preempt_hit;
    logic             yield_en;
    logic             take_win;
    logic             go_idle;
    logic [31:0]      slices [MAX_REQ];

    for (genvar g = 0; g < MAX_REQ; g++) begin : g_slice
        if (g < N_REQ) begin : g_used
            assign slices[g] = bus.val_in[32*g +: 32];
        end else begin : g_pad
            assign slices[g] = '0;
        end
    end

    assign start_idx = (last_q == LAST_IDX) ? '0 : last_q + IDX_W'(1);
    assign excl      = (state == HOLD) ? bus.grant_out : '0;
    assign owner_req = |(bus.req_in & bus.grant_out);
    assign at_max    = (cnt == CNT_MAX);

`ifdef SEG_DISPLAY_ARB_PREEMPT_EN
    assign preempt_hit = (state == HOLD) & bus.req_in[0] & ~bus.grant_out[0];
    assign yield_en    = ~bus.grant_out[0];
`else
    assign preempt_hit = 1'b0;
    assign yield_en    = 1'b1;
`endif

    disp_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (bus.req_in),
        .start (start_idx),
        .excl  (excl),
        .found (found),
        .win   (win_idx)
    );

    // Release and dwell expiry share the picker; both exclude the current owner.
    assign take_win = (state == IDLE) ? found
                    : (!preempt_hit && found && (!owner_req || (at_max && yield_en)));
    assign go_idle  = (state == HOLD) && !preempt_hit && !owner_req && !found;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            cnt            <= '0;
            last_q         <= LAST_IDX;
            bus.grant_out  <= '0;
            bus.owner_out  <= '0;
            bus.val_out    <= IDLE_VAL;
            bus.blank_out  <= 1'b1;
            bus.switch_out <= 1'b0;
        end else begin
            bus.switch_out <= 1'b0;
            if (take_win) begin
                state          <= HOLD;
                cnt            <= '0;
                last_q         <= win_idx;
                bus.grant_out  <= N_REQ'(1) << win_idx;
                bus.owner_out  <= win_idx;
                bus.val_out    <= slices[win_idx];
                bus.blank_out  <= 1'b0;
                bus.switch_out <= 1'b1;
            end else if (preempt_hit) begin
                // Urgent grant leaves last_q alone so rotation resumes where it was.
                cnt            <= '0;
                bus.grant_out  <= N_REQ'(1);
                bus.owner_out  <= '0;
                bus.val_out    <= slices[0];
                bus.switch_out <= 1'b1;
            end else if (go_idle) begin
                state          <= IDLE;
                cnt            <= '0;
                bus.grant_out  <= '0;
                bus.owner_out  <= '0;
                bus.val_out    <= IDLE_VAL;
                bus.blank_out  <= 1'b1;
                bus.switch_out <= 1'b1;
            end else if (state == HOLD) begin
                if (!at_max) begin
                    cnt <= cnt + CNT_W'(1);
                end
                bus.val_out <= slices[bus.owner_out];
            end else begin
                bus.val_out <= IDLE_VAL;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - directed and randomized checks against a behavioural model
module tb_seg_display_arbiter;

    localparam int          N    = 4;
    localparam int          D    = 4;
    localparam logic [31:0] IDLE = 32'h0BAD_F00D;
`ifdef SEG_DISPLAY_ARB_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_display_arb_if #(.N_REQ(N)) bus ();

    seg_display_arbiter #(
        .N_REQ        (N),
        .DWELL_CYCLES (D),
        .IDLE_VAL     (IDLE)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    int          m_owner;
    int          m_held;
    int          m_last;
    logic [31:0] m_val;
    bit          m_sw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input int from, input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] slice_of(input int i);
        return bus.val_in[32*i +: 32];
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = N - 1;
        m_val   = IDLE;
        m_sw    = 1'b0;
    endtask

    task automatic model_step();
        int prev;
        int w;
        logic [N-1:0] r;
        logic [N-1:0] others;
        prev = m_owner;
        r    = bus.req_in;
        if (m_owner < 0) begin
            w = rr(m_last, r);
            if (w >= 0) begin
                m_owner = w; m_held = 0; m_last = w;
            end
        end else begin
            others = r & ~(N'(1) << m_owner);
            if (PRE && r[0] && m_owner != 0) begin
                m_owner = 0; m_held = 0;
            end else if (!r[m_owner]) begin
                w = rr(m_last, others);
                m_owner = w; m_held = 0;
                if (w >= 0) m_last = w;
            end else if (m_held >= D - 1 && !(PRE && m_owner == 0)) begin
                w = rr(m_last, others);
                if (w >= 0) begin
                    m_owner = w; m_held = 0; m_last = w;
                end
            end else if (m_held < D - 1) begin
                m_held++;
            end
        end
        m_sw  = (m_owner != prev);
        m_val = (m_owner < 0) ? IDLE : slice_of(m_owner);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_grant"}, 32'(bus.grant_out), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        chk({tag, "_owner"}, 32'(bus.owner_out), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        chk({tag, "_val"},   bus.val_out, m_val);
        chk({tag, "_blank"}, 32'(bus.blank_out), 32'(m_owner < 0));
        chk({tag, "_switch"}, 32'(bus.switch_out), 32'(m_sw));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic set_val(input int i, input logic [31:0] v);
        bus.val_in[32*i +: 32] = v;
    endtask

    // Reset lands between edges so the outputs must clear without any clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req_in = '0;
        bus.val_in = '0;
        for (int i = 0; i < N; i++) set_val(i, $urandom);
        model_reset();

        // rotation between requesters 1 and 2 with dwell 4
        do_reset();
        bus.req_in = 4'b0110;
        step("t1");
        chk("t1_first_grant", 32'(bus.grant_out), 32'b0010);
        chk("t1_first_switch", 32'(bus.switch_out), 32'd1);
        repeat (4) step("t1");
        chk("t1_dwell_grant", 32'(bus.grant_out), 32'b0100);
        repeat (4) step("t1");
        chk("t1_back_grant", 32'(bus.grant_out), 32'b0010);

        // lone requester keeps the display, then yields at once after saturation
        do_reset();
        set_val(3, 32'hDEAD_BEEF);
        bus.req_in = 4'b1000;
        step("t2");
        repeat (20) begin
            step("t2");
            chk("t2_no_switch", 32'(bus.switch_out), 32'd0);
        end
        chk("t2_grant", 32'(bus.grant_out), 32'b1000);
        chk("t2_val", bus.val_out, 32'hDEAD_BEEF);
        bus.req_in = 4'b1010;
        step("t2");
        chk("t2_yield", 32'(bus.grant_out), 32'b0010);

        // voluntary release mid-dwell, then release to idle
        do_reset();
        bus.req_in = 4'b0100;
        step("t3");
        bus.req_in = 4'b0101;
        step("t3");
        bus.req_in = 4'b0001;
        step("t3");
        chk("t3_release_grant", 32'(bus.grant_out), 32'b0001);
        bus.req_in = 4'b0000;
        step("t3");
        chk("t3_idle_blank", 32'(bus.blank_out), 32'd1);
        chk("t3_idle_val", bus.val_out, IDLE);
        chk("t3_idle_switch", 32'(bus.switch_out), 32'd1);

        // owner data tracked with one cycle of latency
        do_reset();
        set_val(1, 32'h1234_5678);
        bus.req_in = 4'b0010;
        step("t4");
        chk("t4_val0", bus.val_out, 32'h1234_5678);
        set_val(1, 32'h1234_5679);
        #1;
        chk("t4_val_hold", bus.val_out, 32'h1234_5678);
        step("t4");
        chk("t4_val1", bus.val_out, 32'h1234_5679);

        // reset while holding, then lowest index wins first
        do_reset();
        chk("t5_rst_grant", 32'(bus.grant_out), 32'd0);
        chk("t5_rst_val", bus.val_out, IDLE);
        bus.req_in = 4'b1111;
        step("t5");
        chk("t5_first_grant", 32'(bus.grant_out), 32'b0001);

        if (PRE) begin
            do_reset();
            bus.req_in = 4'b1000;
            step("t6");
            step("t6");
            bus.req_in = 4'b1001;
            step("t6");
            chk("t6_preempt", 32'(bus.grant_out), 32'b0001);
            bus.req_in = 4'b1010;
            step("t6");
            chk("t6_resume", 32'(bus.grant_out), 32'b0010);
        end

        // randomized traffic with occasional resets
        do_reset();
        repeat (600) begin
            if ($urandom_range(0, 3) == 0) bus.req_in = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0) set_val(i, $urandom);
            end
            if ($urandom_range(0, 149) == 0) do_reset();
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
